// File: rtl/note_match_pkg.sv
// Shared definitions for the note matcher: default sizes and windows,
// channel state encoding, hit grades and the per-cycle event payload.
package note_match_pkg;

  localparam int unsigned NUM_NOTES_DEF   = 37;
  localparam int unsigned TIME_W_DEF      = 16;
  localparam int unsigned WIN_GOOD_DEF    = 100;
  localparam int unsigned WIN_PERFECT_DEF = 30;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_ARMED = 1'b1
  } ch_state_e;

  localparam logic GRADE_GOOD    = 1'b0;
  localparam logic GRADE_PERFECT = 1'b1;

  // One channel's outcome for a cycle; at most one of match/miss/stray is set.
  typedef struct packed {
    logic match;
    logic perfect;
    logic miss;
    logic stray;
  } ch_event_t;

endpackage

// File: rtl/note_match_channel.sv
// One note channel: holds a pending target time and grades player edges.
// Ports:
//   clk, rst_n       clock, async active-low reset
//   flush            synchronous clear to EMPTY, suppresses all events
//   song_time        current song time
//   note_edge        rising edge of the player input (from the top level)
//   meta_time        next target time, meta_available qualifies it
//   meta_request     channel is EMPTY and accepts a target
//   match_*          hit pulse, grade and latched hit time
//   miss_trigger     target left the window without a hit
//   stray_trigger    edge with no armed target in window
module note_match_channel
  import note_match_pkg::*;
#(
  parameter int unsigned TIME_W      = TIME_W_DEF,
  parameter int unsigned WIN_GOOD    = WIN_GOOD_DEF,
  parameter int unsigned WIN_PERFECT = WIN_PERFECT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic [TIME_W-1:0] song_time,
  input  logic              note_edge,
  input  logic [TIME_W-1:0] meta_time,
  input  logic              meta_available,
  output logic              meta_request,
  output logic              match_trigger,
  output logic              match_perfect,
  output logic [TIME_W-1:0] match_time,
  output logic              miss_trigger,
  output logic              stray_trigger
);

  // One extra bit so the difference never wraps near the top of the time range.
  localparam int unsigned DW = TIME_W + 1;
  localparam logic signed [DW-1:0] WIN_GOOD_S    = DW'(WIN_GOOD);
  localparam logic        [DW-1:0] WIN_GOOD_U    = DW'(WIN_GOOD);
  localparam logic        [DW-1:0] WIN_PERFECT_U = DW'(WIN_PERFECT);

  ch_state_e         state_q, state_d;
  logic [TIME_W-1:0] target_q, target_d;
  logic [TIME_W-1:0] match_time_q, match_time_d;
  logic              meta_request_q, meta_request_d;
  ch_event_t         event_q, event_d;

  logic signed [DW-1:0] diff_c;
  logic        [DW-1:0] abs_c;

  // Signed distance of the song position from the target.
  always_comb begin
    diff_c = $signed({1'b0, song_time}) - $signed({1'b0, target_q});
    abs_c  = diff_c[DW-1] ? $unsigned(-diff_c) : $unsigned(diff_c);
  end

  // Next-state and event decode.
  always_comb begin
    state_d      = state_q;
    target_d     = target_q;
    match_time_d = match_time_q;
    event_d      = '0;

    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (meta_available) begin
            target_d = meta_time;
            state_d  = ST_ARMED;
          end
          event_d.stray = note_edge;
        end
        ST_ARMED: begin
          // Target already behind the window: a late edge cannot rescue it.
          if (diff_c > WIN_GOOD_S) begin
            event_d.miss = 1'b1;
            state_d      = ST_EMPTY;
          end else if (note_edge) begin
            if (abs_c <= WIN_GOOD_U) begin
              event_d.match   = 1'b1;
              event_d.perfect = (abs_c <= WIN_PERFECT_U) ? GRADE_PERFECT : GRADE_GOOD;
              match_time_d    = song_time;
              state_d         = ST_EMPTY;
            end else if (diff_c < -WIN_GOOD_S) begin
              event_d.stray = 1'b1;
            end
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end

    meta_request_d = (state_d == ST_EMPTY);
  end

  // Request reset to 1 so it always mirrors the EMPTY state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_EMPTY;
      target_q       <= '0;
      match_time_q   <= '0;
      meta_request_q <= 1'b1;
      event_q        <= '0;
    end else begin
      state_q        <= state_d;
      target_q       <= target_d;
      match_time_q   <= match_time_d;
      meta_request_q <= meta_request_d;
      event_q        <= event_d;
    end
  end

  assign meta_request  = meta_request_q;
  assign match_trigger = event_q.match;
  assign match_perfect = event_q.perfect;
  assign match_time    = match_time_q;
  assign miss_trigger  = event_q.miss;
  assign stray_trigger = event_q.stray;

endmodule

// File: rtl/note_matcher_array.sv
// Multi-channel note matcher: edge-detects each player input and feeds an
// independent matcher channel per note lane.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   flush             clear all channels (restart/seek)
//   song_time         current song time
//   note_in           raw per-channel player input level
//   meta_time         packed per-channel target times, channel i at [i*TIME_W +: TIME_W]
//   meta_available    per-channel target valid
//   meta_request      per-channel ready for a target
//   match_trigger/match_perfect/match_time  hit pulse, grade, latched hit time
//   miss_trigger, stray_trigger             miss and stray pulses
module note_matcher_array
  import note_match_pkg::*;
#(
  parameter int unsigned NUM_NOTES   = NUM_NOTES_DEF,
  parameter int unsigned TIME_W      = TIME_W_DEF,
  parameter int unsigned WIN_GOOD    = WIN_GOOD_DEF,
  parameter int unsigned WIN_PERFECT = WIN_PERFECT_DEF
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush,
  input  logic [TIME_W-1:0]           song_time,
  input  logic [NUM_NOTES-1:0]        note_in,
  input  logic [NUM_NOTES*TIME_W-1:0] meta_time,
  input  logic [NUM_NOTES-1:0]        meta_available,
  output logic [NUM_NOTES-1:0]        meta_request,
  output logic [NUM_NOTES-1:0]        match_trigger,
  output logic [NUM_NOTES-1:0]        match_perfect,
  output logic [NUM_NOTES*TIME_W-1:0] match_time,
  output logic [NUM_NOTES-1:0]        miss_trigger,
  output logic [NUM_NOTES-1:0]        stray_trigger
);

  logic [NUM_NOTES-1:0] note_prev_q, note_prev_d;
  logic [NUM_NOTES-1:0] note_edge_c;

  // Previous input level; deliberately untouched by flush so a held key
  // does not look like a fresh press after a seek.
  always_comb begin
    note_prev_d = note_in;
    note_edge_c = note_in & ~note_prev_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      note_prev_q <= '0;
    end else begin
      note_prev_q <= note_prev_d;
    end
  end

  for (genvar i = 0; i < NUM_NOTES; i++) begin : g_ch
    note_match_channel #(
      .TIME_W      (TIME_W),
      .WIN_GOOD    (WIN_GOOD),
      .WIN_PERFECT (WIN_PERFECT)
    ) u_ch (
      .clk            (clk),
      .rst_n          (rst_n),
      .flush          (flush),
      .song_time      (song_time),
      .note_edge      (note_edge_c[i]),
      .meta_time      (meta_time[i*TIME_W +: TIME_W]),
      .meta_available (meta_available[i]),
      .meta_request   (meta_request[i]),
      .match_trigger  (match_trigger[i]),
      .match_perfect  (match_perfect[i]),
      .match_time     (match_time[i*TIME_W +: TIME_W]),
      .miss_trigger   (miss_trigger[i]),
      .stray_trigger  (stray_trigger[i])
    );
  end

endmodule

// File: tb/tb_note_matcher_array.sv
module tb_note_matcher_array;

  localparam int unsigned N  = 37;
  localparam int unsigned TW = 16;

  logic            clk;
  logic            rst_n;
  logic            flush;
  logic [TW-1:0]   song_time;
  logic [N-1:0]    note_in;
  logic [N*TW-1:0] meta_time;
  logic [N-1:0]    meta_available;
  logic [N-1:0]    meta_request;
  logic [N-1:0]    match_trigger;
  logic [N-1:0]    match_perfect;
  logic [N*TW-1:0] match_time;
  logic [N-1:0]    miss_trigger;
  logic [N-1:0]    stray_trigger;

  note_matcher_array #(
    .NUM_NOTES(N), .TIME_W(TW), .WIN_GOOD(100), .WIN_PERFECT(30)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .song_time(song_time),
    .note_in(note_in), .meta_time(meta_time), .meta_available(meta_available),
    .meta_request(meta_request), .match_trigger(match_trigger),
    .match_perfect(match_perfect), .match_time(match_time),
    .miss_trigger(miss_trigger), .stray_trigger(stray_trigger)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int unsigned  due;
    logic [N-1:0] match;
    logic [N-1:0] perf;
    logic [N-1:0] miss;
    logic [N-1:0] stray;
    logic [N-1:0] req;
    int           mt_ch;
    logic [TW-1:0] mt_val;
  } exp_t;

  exp_t         exp_q[$];
  logic [N-1:0] req_model;
  int unsigned  cyc_cnt = 0;
  int           checks = 0;
  int           errors = 0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Scoreboard: compare every output due this cycle against what was queued.
  always @(negedge clk) begin
    exp_t e;
    while (exp_q.size() > 0 && exp_q[0].due == cyc_cnt) begin
      e = exp_q.pop_front();
      checks++;
      if (match_trigger !== e.match) begin
        errors++;
        $display("FAIL match_trigger cyc=%0d got=%h exp=%h", cyc_cnt, match_trigger, e.match);
      end
      checks++;
      if ((match_perfect & e.match) !== e.perf) begin
        errors++;
        $display("FAIL match_perfect cyc=%0d got=%h exp=%h", cyc_cnt, match_perfect & e.match, e.perf);
      end
      checks++;
      if (miss_trigger !== e.miss) begin
        errors++;
        $display("FAIL miss_trigger cyc=%0d got=%h exp=%h", cyc_cnt, miss_trigger, e.miss);
      end
      checks++;
      if (stray_trigger !== e.stray) begin
        errors++;
        $display("FAIL stray_trigger cyc=%0d got=%h exp=%h", cyc_cnt, stray_trigger, e.stray);
      end
      checks++;
      if (meta_request !== e.req) begin
        errors++;
        $display("FAIL meta_request cyc=%0d got=%h exp=%h", cyc_cnt, meta_request, e.req);
      end
      if (e.mt_ch >= 0) begin
        checks++;
        if (match_time[e.mt_ch*TW +: TW] !== e.mt_val) begin
          errors++;
          $display("FAIL match_time ch=%0d got=%0d exp=%0d", e.mt_ch,
                   match_time[e.mt_ch*TW +: TW], e.mt_val);
        end
      end
    end
  end

  function automatic exp_t dflt();
    exp_t e;
    e.due    = 0;
    e.match  = '0;
    e.perf   = '0;
    e.miss   = '0;
    e.stray  = '0;
    e.req    = req_model;
    e.mt_ch  = -1;
    e.mt_val = '0;
    return e;
  endfunction

  // Queue the expectation for the inputs now applied, then advance one cycle.
  task automatic step(input exp_t e);
    e.due = cyc_cnt + 1;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic set_meta(input int ch, input logic [TW-1:0] t);
    meta_time[ch*TW +: TW] = t;
    meta_available[ch]     = 1'b1;
  endtask

  task automatic clr_meta();
    meta_available = '0;
  endtask

  task automatic do_flush();
    flush     = 1'b1;
    req_model = '1;
    clr_meta();
    step(dflt());
    flush = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; song_time = '0; note_in = '0;
    meta_time = '0; meta_available = '0; req_model = '1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (match_trigger !== '0 || miss_trigger !== '0 || stray_trigger !== '0 || match_perfect !== '0) begin
      errors++;
      $display("FAIL reset_triggers got=%h/%h/%h/%h exp=0", match_trigger, miss_trigger,
               stray_trigger, match_perfect);
    end
    checks++;
    if (match_time !== '0) begin
      errors++;
      $display("FAIL reset_match_time got=%h exp=0", match_time);
    end
    rst_n = 1'b1;
    step(dflt());
  endtask

  task automatic test_load();
    song_time = 16'd900;
    set_meta(0, 16'd1000);
    req_model[0] = 1'b0;
    step(dflt());
    clr_meta();
    repeat (2) step(dflt());
  endtask

  task automatic test_perfect();
    exp_t e;
    song_time = 16'd1020;
    note_in[0] = 1'b1;
    req_model[0] = 1'b1;
    e = dflt(); e.match[0] = 1'b1; e.perf[0] = 1'b1; e.mt_ch = 0; e.mt_val = 16'd1020;
    step(e);
    note_in[0] = 1'b0;
    step(dflt());
  endtask

  task automatic test_good_boundary();
    exp_t e;
    set_meta(0, 16'd1000); req_model[0] = 1'b0; step(dflt()); clr_meta();
    song_time = 16'd1100; note_in[0] = 1'b1; req_model[0] = 1'b1;
    e = dflt(); e.match[0] = 1'b1; e.mt_ch = 0; e.mt_val = 16'd1100;
    step(e);
    note_in[0] = 1'b0; step(dflt());
    do_flush();
    song_time = 16'd890;
    set_meta(0, 16'd1000); req_model[0] = 1'b0; step(dflt()); clr_meta();
    // One ms too early: stray, target kept
    song_time = 16'd899; note_in[0] = 1'b1;
    e = dflt(); e.stray[0] = 1'b1;
    step(e);
    note_in[0] = 1'b0; song_time = 16'd900; step(dflt());
    // Exactly on the early edge of the GOOD window
    note_in[0] = 1'b1; req_model[0] = 1'b1;
    e = dflt(); e.match[0] = 1'b1; e.mt_ch = 0; e.mt_val = 16'd900;
    step(e);
    note_in[0] = 1'b0; step(dflt());
  endtask

  task automatic test_miss();
    exp_t e;
    song_time = 16'd1000;
    set_meta(0, 16'd1000); req_model[0] = 1'b0; step(dflt()); clr_meta();
    song_time = 16'd1100; step(dflt());
    song_time = 16'd1101; req_model[0] = 1'b1;
    e = dflt(); e.miss[0] = 1'b1;
    step(e);
    song_time = 16'd1102; step(dflt());
  endtask

  task automatic test_stray_empty();
    exp_t e;
    song_time = 16'd1200; note_in[1] = 1'b1;
    e = dflt(); e.stray[1] = 1'b1; step(e);
    note_in[1] = 1'b0; step(dflt());
    // Edge on the load cycle still counts as stray
    note_in[1] = 1'b1; set_meta(1, 16'd2000); req_model[1] = 1'b0;
    e = dflt(); e.stray[1] = 1'b1; step(e);
    note_in[1] = 1'b0; clr_meta(); step(dflt());
  endtask

  task automatic test_parallel();
    exp_t e;
    do_flush();
    song_time = 16'd5000;
    set_meta(3, 16'd5000); set_meta(36, 16'd5010);
    req_model[3] = 1'b0; req_model[36] = 1'b0;
    step(dflt()); clr_meta();
    song_time = 16'd5020; note_in[3] = 1'b1; note_in[36] = 1'b1;
    req_model[3] = 1'b1; req_model[36] = 1'b1;
    e = dflt(); e.match[3] = 1'b1; e.match[36] = 1'b1; e.perf[3] = 1'b1; e.perf[36] = 1'b1;
    e.mt_ch = 36; e.mt_val = 16'd5020;
    step(e);
    checks++;
    if (match_time[3*TW +: TW] !== 16'd5020) begin
      errors++;
      $display("FAIL parallel_match_time3 got=%0d exp=5020", match_time[3*TW +: TW]);
    end
    // Keep the inputs held: a re-armed ch3 and an empty ch36 see no new edge
    song_time = 16'd5025;
    set_meta(3, 16'd5030); req_model[3] = 1'b0; step(dflt()); clr_meta();
    for (int i = 0; i < 48; i++) step(dflt());
    note_in[3] = 1'b0; note_in[36] = 1'b0; step(dflt());
    note_in[3] = 1'b1; req_model[3] = 1'b1;
    e = dflt(); e.match[3] = 1'b1; e.perf[3] = 1'b1; e.mt_ch = 3; e.mt_val = 16'd5025;
    step(e);
    note_in[3] = 1'b0; step(dflt());
  endtask

  task automatic test_flush();
    do_flush();
    song_time = 16'd6000;
    set_meta(5, 16'd6000); req_model[5] = 1'b0; step(dflt()); clr_meta();
    // Would be a miss on ch5, a load on ch6 and a stray on ch7 without flush
    song_time = 16'd6200; flush = 1'b1; set_meta(6, 16'd6300); note_in[7] = 1'b1;
    req_model = '1;
    step(dflt());
    flush = 1'b0; clr_meta(); step(dflt());
    note_in[7] = 1'b0; step(dflt());
  endtask

  task automatic test_overflow();
    exp_t e;
    do_flush();
    song_time = 16'd20;
    set_meta(8, 16'hFFFF); req_model[8] = 1'b0; step(dflt()); clr_meta();
    note_in[8] = 1'b1;
    e = dflt(); e.stray[8] = 1'b1; step(e);
    note_in[8] = 1'b0; step(dflt());
    song_time = 16'hFFFF; note_in[8] = 1'b1; req_model[8] = 1'b1;
    e = dflt(); e.match[8] = 1'b1; e.perf[8] = 1'b1; e.mt_ch = 8; e.mt_val = 16'hFFFF;
    step(e);
    note_in[8] = 1'b0;
    set_meta(9, 16'd10); req_model[9] = 1'b0; step(dflt()); clr_meta();
    req_model[9] = 1'b1;
    e = dflt(); e.miss[9] = 1'b1; step(e);
  endtask

  task automatic test_async_reset();
    exp_t e;
    do_flush();
    song_time = 16'd7000;
    set_meta(5, 16'd7000); req_model[5] = 1'b0; step(dflt()); clr_meta();
    note_in[5] = 1'b1; req_model[5] = 1'b1;
    e = dflt(); e.match[5] = 1'b1; e.perf[5] = 1'b1; e.mt_ch = 5; e.mt_val = 16'd7000;
    step(e);
    @(negedge clk);
    #1;
    note_in = '0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (match_trigger !== '0 || match_perfect !== '0 || miss_trigger !== '0 || stray_trigger !== '0) begin
      errors++;
      $display("FAIL async_reset_triggers got=%h/%h/%h/%h exp=0", match_trigger, match_perfect,
               miss_trigger, stray_trigger);
    end
    checks++;
    if (match_time !== '0) begin
      errors++;
      $display("FAIL async_reset_match_time got=%h exp=0", match_time);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1; req_model = '1;
    repeat (2) step(dflt());
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_load();
    test_perfect();
    test_good_boundary();
    test_miss();
    test_stray_empty();
    test_parallel();
    test_flush();
    test_overflow();
    test_async_reset();
    repeat (2) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
